dfi_cmd_decoder: RTL and testbench

- PHY-side (DST) end of the DDR2 DFI control and write-data interfaces.
- Samples cke/cs_n/ras_n/cas_n/we_n/ba/addr/odt plus wrdata_en/wrdata/wrdata_mask every clk.
- Decodes DRAM commands, tracks per-bank open/closed state and pairs each WR command with its write-data burst after write latency.
- Flags protocol violations. Used as the PHY-facing front end of the DRAM model and as a bus checker in controller benches.

---
 rtl/dfi_dec_pkg.sv | 61 ++++++
 rtl/dfi_wr_pend_fifo.sv | 70 +++++++
 rtl/dfi_cmd_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_dfi_cmd_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfi_dec_pkg.sv
// Shared types for the DFI command decoder: command/error codes and pending-WR entry.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
//
// Optional feature macro: DFI_DEC_ROW_TRACK_EN adds a row field to the pending entry.
// Field widths are fixed maxima. The top zero-extends its narrower bank, address and
// countdown values into these fields.
package dfi_dec_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6,
        CMD_MRS  = 3'd7
    } dfi_cmd_t;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_ACT_OPEN      = 3'd1,
        ERR_CLOSED_ACCESS = 3'd2,
        ERR_REF_OPEN      = 3'd3,
        ERR_ILLEGAL       = 3'd4,
        ERR_UNEXP_WDATA   = 3'd5,
        ERR_MISSED_WDATA  = 3'd6,
        ERR_OVERFLOW      = 3'd7
    } dfi_err_t;

    localparam int PEND_BA_W   = 4;   // covers up to 16 banks
    localparam int PEND_ADDR_W = 16;  // covers DFI address widths up to 16
    localparam int PEND_CNT_W  = 4;   // countdown holds WL-1, and WL is at most 15

    typedef struct packed {
        logic [PEND_BA_W-1:0]   ba;
        logic [PEND_ADDR_W-1:0] col;
`ifdef DFI_DEC_ROW_TRACK_EN
        logic [PEND_ADDR_W-1:0] row;
`endif
        logic [PEND_CNT_W-1:0]  cnt;
    } pend_entry_t;

    // Map {ras_n,cas_n,we_n} to a command. 110 (reserved) and 111 both yield NOP.
    // The caller flags 110 separately.
    function automatic dfi_cmd_t decode_cmd(input logic [2:0] rcw, input logic a10);
        dfi_cmd_t c;
        case (rcw)
            3'b011:  c = CMD_ACT;
            3'b101:  c = CMD_RD;
            3'b100:  c = CMD_WR;
            3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
            3'b001:  c = CMD_REF;
            3'b000:  c = CMD_MRS;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dfi_wr_pend_fifo.sv
// Pending-WR queue: entries count down to their write-data slot; head_due marks the head ready.
// Latency: push visible at head next cycle; countdown decrements once per cycle from push+1.
// Backpressure: none upstream. A push while full is ignored unless a pop happens in the same cycle.
//
// Ports: push/push_entry (enqueue), pop (dequeue head), head/head_due (head entry, countdown done),
//        full/empty (occupancy). DEPTH must be a power of 2 and at least 2.
module dfi_wr_pend_fifo
    import dfi_dec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  pend_entry_t push_entry,
    input  logic        pop,
    output pend_entry_t head,
    output logic        head_due,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pend_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // Popping the head frees a slot in the same cycle, so a push is accepted even when full.
    assign push_ok  = push && (!full || pop_ok);
    assign head     = mem[rd_ptr];
    assign head_due = !empty && (head.cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Free slots count down too. That is harmless because a push overwrites the whole entry.
            for (int i = 0; i < DEPTH; i++) begin
                if (mem[i].cnt != '0) begin
                    mem[i].cnt <= mem[i].cnt - 1'b1;
                end
            end
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dfi_cmd_decoder.sv
// PHY-side DFI decoder: decodes DRAM commands, tracks bank state, pairs WRs with write-data bursts.
// Latency: cmd_*, bank_open, wd_* and err_* are registered one cycle after the sampling edge.
// Backpressure: none. This is a passive sink, so protocol violations are reported on err_*.
//
// Ports: DFI control (cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt) and write data
//        (wrdata_en, wrdata, wrdata_mask) in; decoded command (cmd_*), bank_open,
//        write beats (wd_*), errors (err_valid/err_code/err_sticky, err_clr in) out.
// Optional macro DFI_DEC_ROW_TRACK_EN stores the row for each bank and adds the cmd_row and wd_row outputs.
module dfi_cmd_decoder
    import dfi_dec_pkg::*;
#(
    parameter int NUM_BANKS   = 8,
    parameter int ADDR_WIDTH  = 14,
    parameter int CS_WIDTH    = 1,
    parameter int WL          = 2,
    parameter int BURST_BEATS = 2,
    parameter int PEND_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CS_WIDTH-1:0]          cke,
    input  logic [CS_WIDTH-1:0]          cs_n,
    input  logic                         ras_n,
    input  logic                         cas_n,
    input  logic                         we_n,
    input  logic [$clog2(NUM_BANKS)-1:0] ba,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [CS_WIDTH-1:0]          odt,
    input  logic                         wrdata_en,
    input  logic [63:0]                  wrdata,
    input  logic [7:0]                   wrdata_mask,
    output logic                         cmd_valid,
    output dfi_cmd_t                     cmd_code,
    output logic [$clog2(NUM_BANKS)-1:0] cmd_ba,
    output logic [ADDR_WIDTH-1:0]        cmd_addr,
`ifdef DFI_DEC_ROW_TRACK_EN
    output logic [ADDR_WIDTH-1:0]        cmd_row,
    output logic [ADDR_WIDTH-1:0]        wd_row,
`endif
    output logic [NUM_BANKS-1:0]         bank_open,
    output logic                         wd_valid,
    output logic [63:0]                  wd_data,
    output logic [7:0]                   wd_mask,
    output logic [$clog2(NUM_BANKS)-1:0] wd_ba,
    output logic [ADDR_WIDTH-1:0]        wd_col,
    output logic                         wd_last,
    output logic                         err_valid,
    output dfi_err_t                     err_code,
    output logic                         err_sticky,
    input  logic                         err_clr
);

    localparam int BA_W   = $clog2(NUM_BANKS);
    localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

    // ---------------- command decode ----------------
    logic       dec_en;
    logic [2:0] rcw;
    dfi_cmd_t   dec_cmd;
    dfi_err_t   cmd_err;

    // A command is decoded only when clocks are enabled and at least one rank is selected.
    assign dec_en = (|cke) && !(&cs_n);
    assign rcw    = {ras_n, cas_n, we_n};

    always_comb begin
        dec_cmd = CMD_NOP;
        cmd_err = ERR_NONE;
        if (dec_en) begin
            dec_cmd = decode_cmd(rcw, addr[10]);
            case (dec_cmd)
                CMD_ACT:        if (bank_open[ba])  cmd_err = ERR_ACT_OPEN;
                CMD_RD, CMD_WR: if (!bank_open[ba]) cmd_err = ERR_CLOSED_ACCESS;
                CMD_REF:        if (|bank_open)     cmd_err = ERR_REF_OPEN;
                default:        ;
            endcase
            if (rcw == 3'b110) begin
                cmd_err = ERR_ILLEGAL;
            end
        end
    end

`ifdef DFI_DEC_ROW_TRACK_EN
    logic [ADDR_WIDTH-1:0] row_mem [NUM_BANKS];
`endif

    // ---------------- pending WR tracking ----------------
    pend_entry_t      push_entry;
    pend_entry_t      head;
    logic             head_due;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_push;
    logic             beat;
    logic             last_beat;
    logic             missed;
    logic             unexp;
    logic             fifo_pop;
    logic             overflow;
    logic [BEAT_W-1:0] beat_cnt;
    dfi_err_t         err_now;

    assign wr_push   = (dec_cmd == CMD_WR);
    assign beat      = head_due && wrdata_en;
    assign last_beat = beat && (beat_cnt == BEAT_W'(BURST_BEATS - 1));
    // Any cycle without data while the head is due (first beat or mid-burst) abandons the burst.
    assign missed    = head_due && !wrdata_en;
    assign unexp     = wrdata_en && !head_due;
    assign fifo_pop  = last_beat || missed;
    assign overflow  = wr_push && fifo_full && !fifo_pop;

    always_comb begin
        push_entry     = '0;
        push_entry.ba  = PEND_BA_W'(ba);
        push_entry.col = PEND_ADDR_W'(addr);
        // Stored as WL-1 because the countdown also runs in the cycle after the push.
        // The head is then due exactly WL edges after the WR was sampled.
        push_entry.cnt = PEND_CNT_W'(WL - 1);
`ifdef DFI_DEC_ROW_TRACK_EN
        push_entry.row = PEND_ADDR_W'(row_mem[ba]);
`endif
    end

    dfi_wr_pend_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_pend (
        .clk        (clk),
        .rst        (rst),
        .push       (wr_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .head_due   (head_due),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A single error is reported per cycle. Write-path errors take precedence over command errors.
    always_comb begin
        err_now = cmd_err;
        if (unexp)    err_now = ERR_UNEXP_WDATA;
        if (missed)   err_now = ERR_MISSED_WDATA;
        if (overflow) err_now = ERR_OVERFLOW;
    end

    // ---------------- registered outputs and state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid  <= 1'b0;
            cmd_code   <= CMD_NOP;
            cmd_ba     <= '0;
            cmd_addr   <= '0;
            bank_open  <= '0;
            wd_valid   <= 1'b0;
            wd_data    <= '0;
            wd_mask    <= '0;
            wd_ba      <= '0;
            wd_col     <= '0;
            wd_last    <= 1'b0;
            beat_cnt   <= '0;
            err_valid  <= 1'b0;
            err_code   <= ERR_NONE;
            err_sticky <= 1'b0;
        end else begin
            cmd_valid <= (dec_cmd != CMD_NOP);
            if (dec_cmd != CMD_NOP) begin
                cmd_code <= dec_cmd;
                cmd_ba   <= ba;
                cmd_addr <= addr;
            end

            case (dec_cmd)
                CMD_ACT:  bank_open[ba] <= 1'b1;
                CMD_PRE:  bank_open[ba] <= 1'b0;
                CMD_PREA: bank_open     <= '0;
                default:  ;
            endcase

            wd_valid <= beat;
            wd_last  <= last_beat;
            if (beat) begin
                wd_data <= wrdata;
                wd_mask <= wrdata_mask;
                wd_ba   <= head.ba[BA_W-1:0];
                wd_col  <= head.col[ADDR_WIDTH-1:0];
            end

            if (fifo_pop) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            err_valid  <= (err_now != ERR_NONE);
            err_code   <= err_now;
            // A new error wins over a clear in the same cycle.
            err_sticky <= (err_sticky && !err_clr) || (err_now != ERR_NONE);
        end
    end

`ifdef DFI_DEC_ROW_TRACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                row_mem[i] <= '0;
            end
            cmd_row <= '0;
            wd_row  <= '0;
        end else begin
            if (dec_cmd == CMD_ACT) begin
                row_mem[ba] <= addr;
            end
            case (dec_cmd)
                CMD_ACT:        cmd_row <= addr;
                CMD_RD, CMD_WR: cmd_row <= row_mem[ba];
                default:        cmd_row <= '0;
            endcase
            if (beat) begin
                wd_row <= head.row[ADDR_WIDTH-1:0];
            end
        end
    end
`endif

    // odt is sampled by the interface but carries no decode meaning here.
    // Parts of the head entry, such as the padding bits and the countdown, are consumed only inside the FIFO.
    logic unused_ok;
    assign unused_ok = ^{odt, head, fifo_empty};

endmodule

// File: tb/tb_dfi_cmd_decoder.sv
module tb_dfi_cmd_decoder;
    import dfi_dec_pkg::*;

    localparam logic [2:0] ENC_ACT = 3'b011;
    localparam logic [2:0] ENC_RD  = 3'b101;
    localparam logic [2:0] ENC_WR  = 3'b100;
    localparam logic [2:0] ENC_PRE = 3'b010;
    localparam logic [2:0] ENC_REF = 3'b001;
    localparam logic [2:0] ENC_MRS = 3'b000;
    localparam logic [2:0] ENC_NOP = 3'b111;
    localparam logic [2:0] ENC_RSV = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  cke, cs_n, odt;
    logic        ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        wrdata_en;
    logic [63:0] wrdata;
    logic [7:0]  wrdata_mask;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [2:0]  cmd_ba;
    logic [13:0] cmd_addr;
    logic [7:0]  bank_open;
    logic        wd_valid;
    logic [63:0] wd_data;
    logic [7:0]  wd_mask;
    logic [2:0]  wd_ba;
    logic [13:0] wd_col;
    logic        wd_last;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        err_sticky;
    logic        err_clr;
`ifdef DFI_DEC_ROW_TRACK_EN
    logic [13:0] cmd_row;
    logic [13:0] wd_row;
`endif

    dfi_cmd_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .cke         (cke),
        .cs_n        (cs_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .ba          (ba),
        .addr        (addr),
        .odt         (odt),
        .wrdata_en   (wrdata_en),
        .wrdata      (wrdata),
        .wrdata_mask (wrdata_mask),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_ba      (cmd_ba),
        .cmd_addr    (cmd_addr),
`ifdef DFI_DEC_ROW_TRACK_EN
        .cmd_row     (cmd_row),
        .wd_row      (wd_row),
`endif
        .bank_open   (bank_open),
        .wd_valid    (wd_valid),
        .wd_data     (wd_data),
        .wd_mask     (wd_mask),
        .wd_ba       (wd_ba),
        .wd_col      (wd_col),
        .wd_last     (wd_last),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [2:0] rcw, input logic [2:0] b, input logic [13:0] a);
        cke = 1'b1;
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = rcw;
        ba = b;
        addr = a;
    endtask

    task automatic idle();
        drive_cmd(ENC_NOP, 3'd0, 14'd0);
        wrdata_en = 1'b0;
    endtask

    task automatic beat_in(input logic [63:0] d, input logic [7:0] m);
        wrdata_en = 1'b1;
        wrdata = d;
        wrdata_mask = m;
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        odt = 1'b0;
        wrdata = '0;
        wrdata_mask = '0;
        idle();
        step();
        step();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_bank_open", bank_open, 0);
        chk("rst_wd_valid", wd_valid, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_sticky", err_sticky, 0);
        rst = 1'b0;

        // ACT then PRE on bank 2
        drive_cmd(ENC_ACT, 3'd2, 14'h1A5);
        step();
        chk("act_valid", cmd_valid, 1);
        chk("act_code", cmd_code, 1);
        chk("act_ba", cmd_ba, 2);
        chk("act_addr", cmd_addr, 14'h1A5);
        chk("act_bank_open", bank_open, 8'h04);
        chk("act_no_err", err_valid, 0);
        drive_cmd(ENC_PRE, 3'd2, 14'h0);
        step();
        chk("pre_code", cmd_code, 4);
        chk("pre_bank_open", bank_open, 8'h00);
        idle();
        step();
        chk("nop_no_strobe", cmd_valid, 0);

        // Normal write with a 2-beat burst, WL=2
        drive_cmd(ENC_ACT, 3'd0, 14'h10);
        step();
        drive_cmd(ENC_WR, 3'd0, 14'h40);
        step();
        chk("wr_code", cmd_code, 3);
        chk("wr_no_err", err_valid, 0);
        idle();
        step();
        chk("wr_gap_no_beat", wd_valid, 0);
        beat_in(64'hAAAA_0000_0000_0001, 8'h0F);
        step();
        chk("wr_b0_valid", wd_valid, 1);
        chk("wr_b0_data", wd_data, 64'hAAAA_0000_0000_0001);
        chk("wr_b0_mask", wd_mask, 8'h0F);
        chk("wr_b0_col", wd_col, 14'h40);
        chk("wr_b0_last", wd_last, 0);
        beat_in(64'hBBBB_0000_0000_0002, 8'hF0);
        step();
        chk("wr_b1_valid", wd_valid, 1);
        chk("wr_b1_data", wd_data, 64'hBBBB_0000_0000_0002);
        chk("wr_b1_last", wd_last, 1);
        chk("wr_b1_ba", wd_ba, 0);
        idle();
        step();
        chk("wr_done_valid", wd_valid, 0);
        chk("wr_sticky_clean", err_sticky, 0);

        // WR to closed bank 1: error reported, but the data is still paired
        drive_cmd(ENC_WR, 3'd1, 14'h22);
        step();
        chk("closed_valid", cmd_valid, 1);
        chk("closed_err", err_valid, 1);
        chk("closed_code", err_code, 2);
        chk("closed_sticky", err_sticky, 1);
        idle();
        err_clr = 1'b1;
        step();
        chk("clr_sticky", err_sticky, 0);
        chk("clr_err_pulse", err_valid, 0);
        err_clr = 1'b0;
        beat_in(64'hC, 8'h01);
        step();
        chk("closed_b0_valid", wd_valid, 1);
        chk("closed_b0_ba", wd_ba, 1);
        chk("closed_b0_col", wd_col, 14'h22);
        beat_in(64'hD, 8'h02);
        step();
        chk("closed_b1_last", wd_last, 1);
        chk("closed_b1_data", wd_data, 64'hD);

        // Missing write data is detected WL edges after the WR
        drive_cmd(ENC_WR, 3'd0, 14'h8);
        wrdata_en = 1'b0;
        step();
        idle();
        step();
        chk("miss_early", err_valid, 0);
        step();
        chk("miss_err", err_valid, 1);
        chk("miss_code", err_code, 6);
        step();
        chk("miss_once", err_valid, 0);
        chk("miss_no_beat", wd_valid, 0);

        // Unexpected data with an empty FIFO, and a clear in the same cycle as a new error
        err_clr = 1'b1;
        step();
        chk("pre_unexp_sticky", err_sticky, 0);
        beat_in(64'hE, 8'h00);
        step();
        chk("unexp_err", err_valid, 1);
        chk("unexp_code", err_code, 5);
        chk("unexp_set_wins", err_sticky, 1);
        chk("unexp_dropped", wd_valid, 0);
        err_clr = 1'b0;

        // Command errors and bank state (bank 0 is open)
        drive_cmd(ENC_ACT, 3'd0, 14'h11);
        wrdata_en = 1'b0;
        step();
        chk("actopen_code", err_code, 1);
        chk("actopen_bank", bank_open, 8'h01);
        drive_cmd(ENC_REF, 3'd0, 14'h0);
        step();
        chk("refopen_cmd", cmd_code, 6);
        chk("refopen_code", err_code, 3);
        drive_cmd(ENC_RSV, 3'd0, 14'h0);
        step();
        chk("illegal_no_strobe", cmd_valid, 0);
        chk("illegal_code", err_code, 4);
        drive_cmd(ENC_PRE, 3'd6, 14'h400);
        step();
        chk("prea_code", cmd_code, 5);
        chk("prea_bank", bank_open, 8'h00);
        drive_cmd(ENC_REF, 3'd0, 14'h0);
        step();
        chk("ref_ok_code", cmd_code, 6);
        chk("ref_ok_err", err_valid, 0);
        drive_cmd(ENC_MRS, 3'd1, 14'h123);
        step();
        chk("mrs_code", cmd_code, 7);
        chk("mrs_addr", cmd_addr, 14'h123);

        // No decode under cke low or full deselect
        drive_cmd(ENC_RD, 3'd2, 14'h5);
        cke = 1'b0;
        step();
        chk("cke0_no_strobe", cmd_valid, 0);
        chk("cke0_no_err", err_valid, 0);
        drive_cmd(ENC_RSV, 3'd0, 14'h0);
        cs_n = 1'b1;
        step();
        chk("desel_no_strobe", cmd_valid, 0);
        chk("desel_no_err", err_valid, 0);

        // Overflow: back-to-back WRs with continuous data. Entries drain at one per 2 cycles,
        // so the 7th WR finds 4 entries and no pop happens in that cycle.
        drive_cmd(ENC_ACT, 3'd5, 14'h77);
        step();
        for (int i = 0; i < 7; i++) begin
            drive_cmd(ENC_WR, 3'd5, 14'(i));
            if (i >= 2) beat_in(64'(i), 8'h00);
            else wrdata_en = 1'b0;
            step();
            chk($sformatf("ovf_beat_%0d", i), wd_valid, (i >= 2) ? 1 : 0);
            if (i < 6) chk($sformatf("ovf_noerr_%0d", i), err_valid, 0);
        end
        chk("ovf_err", err_valid, 1);
        chk("ovf_code", err_code, 7);
        chk("ovf_head_col", wd_col, 14'd2);
        chk("ovf_head_ba", wd_ba, 5);
        chk("ovf_not_last", wd_last, 0);

        // Asynchronous reset in the middle of the burst
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bank", bank_open, 0);
        chk("arst_wd_valid", wd_valid, 0);
        chk("arst_sticky", err_sticky, 0);
        idle();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("post_rst_no_missed", err_valid, 0);
        chk("post_rst_no_beat", wd_valid, 0);

`ifdef DFI_DEC_ROW_TRACK_EN
        drive_cmd(ENC_ACT, 3'd3, 14'h2F0);
        step();
        chk("row_act", cmd_row, 14'h2F0);
        drive_cmd(ENC_RD, 3'd3, 14'h10);
        step();
        chk("row_rd_code", cmd_code, 2);
        chk("row_rd_row", cmd_row, 14'h2F0);
        chk("row_rd_col", cmd_addr, 14'h10);
        drive_cmd(ENC_WR, 3'd3, 14'h18);
        step();
        idle();
        step();
        beat_in(64'h1, 8'h00);
        step();
        chk("row_wd_row", wd_row, 14'h2F0);
        idle();
        step();
        idle();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
